// File: rtl/pad_cond_pkg.sv
// Shared reset-sequencer state type and default timing constants for the pad input conditioner.
package pad_cond_pkg;

    typedef enum logic [1:0] {
        RST_ACTIVE = 2'd0,
        RST_HOLD   = 2'd1,
        RUN        = 2'd2
    } rst_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 500000;
    localparam int unsigned DEFAULT_RESET_HOLD_CYCLES = 1024;

endpackage

// File: rtl/debounce_cell.sv
// One mechanical input: synchroniser, debounce filter and single-cycle edge pulses.
// Level follows the pin SYNC_STAGES + DEBOUNCE_CYCLES edges after a steady change; no backpressure.
module debounce_cell #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        SYNC_RST_VAL    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   stable_dly_q;
    logic                   sync_w;

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Any sample that agrees with the accepted level restarts the run.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_w != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_w;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q       <= {SYNC_STAGES{SYNC_RST_VAL}};
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = stable_q & ~stable_dly_q;
    assign fall_o  = ~stable_q & stable_dly_q;

endmodule

// File: rtl/pad_input_conditioner.sv
// Board pin conditioner: debounced levels/edges for buttons and switches plus a stretched SoC reset.
// Levels lag pins by SYNC_STAGES + DEBOUNCE_CYCLES edges; soc_rst_no is registered; no backpressure.
module pad_input_conditioner
    import pad_cond_pkg::*;
#(
    parameter int unsigned NUM_INPUTS        = 7,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned RESET_HOLD_CYCLES = DEFAULT_RESET_HOLD_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_INPUTS-1:0] raw_i,
    input  logic                  rst_btn_ni,
    output logic [NUM_INPUTS-1:0] level_o,
    output logic [NUM_INPUTS-1:0] rise_o,
    output logic [NUM_INPUTS-1:0] fall_o,
    output logic                  soc_rst_no
);

    localparam int unsigned   HW        = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

    logic btn_level_w;
    logic btn_rise_unused;
    logic btn_fall_unused;

    for (genvar i = 0; i <= int'(NUM_INPUTS); i++) begin : g_cell
        if (i < int'(NUM_INPUTS)) begin : g_pin
            debounce_cell #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_RST_VAL   (1'b0)
            ) u_cell (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .raw_i  (raw_i[i]),
                .level_o(level_o[i]),
                .rise_o (rise_o[i]),
                .fall_o (fall_o[i])
            );
        end else begin : g_btn
            // Button path starts in the pressed state, so the power-on release
            // travels the full synchroniser + debounce path like any later release.
            debounce_cell #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_RST_VAL   (1'b0)
            ) u_cell (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .raw_i  (rst_btn_ni),
                .level_o(btn_level_w),
                .rise_o (btn_rise_unused),
                .fall_o (btn_fall_unused)
            );
        end
    end

    rst_state_e    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          soc_rst_q;

    // A press always wins over hold expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        unique case (state_q)
            RST_ACTIVE: begin
                if (btn_level_w) state_d = RST_HOLD;
            end
            RST_HOLD: begin
                if (!btn_level_w) begin
                    state_d = RST_ACTIVE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (!btn_level_w) state_d = RST_ACTIVE;
            end
            default: state_d = RST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RST_ACTIVE;
            hold_q    <= '0;
            soc_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            soc_rst_q <= (state_d == RUN);
        end
    end

    assign soc_rst_no = soc_rst_q;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed + randomized bench for pad_input_conditioner against a sample-window reference model.
module tb_pad_input_conditioner;

    localparam int NI   = 7;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          rst_btn_ni;
    logic [NI-1:0] raw_i;
    logic [NI-1:0] level_o, rise_o, fall_o;
    logic          soc_rst_no;

    always #5 clk = ~clk;

    pad_input_conditioner #(
        .NUM_INPUTS       (NI),
        .SYNC_STAGES      (SYNC),
        .DEBOUNCE_CYCLES  (DEB),
        .RESET_HOLD_CYCLES(HOLD)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .raw_i     (raw_i),
        .rst_btn_ni(rst_btn_ni),
        .level_o   (level_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .soc_rst_no(soc_rst_no)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: pin samples per edge; a level flips once the DEB samples seen through
    // the synchroniser all disagree with it. SoC runs once the button level has
    // been high for HOLD+1 consecutive edges.
    logic [NI:0]   hist[$];
    logic [NI:0]   mlevel;
    logic [NI-1:0] exp_rise, exp_fall;
    logic          exp_soc;
    int            btn_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC + DEB; i++) hist.push_back('0);
        mlevel   = '0;
        exp_rise = '0;
        exp_fall = '0;
        exp_soc  = 1'b0;
        btn_run  = 0;
    endtask

    task automatic check_outputs();
        chk("level", 32'(level_o), 32'(mlevel[NI-1:0]));
        chk("rise", 32'(rise_o), 32'(exp_rise));
        chk("fall", 32'(fall_o), 32'(exp_fall));
        chk("soc_rst_n", 32'(soc_rst_no), 32'(exp_soc));
    endtask

    task automatic tick();
        logic [NI:0] pins;
        logic [NI:0] nl;
        bit          diff;
        pins = {rst_btn_ni, raw_i};
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_ni) begin
            model_reset();
        end else begin
            hist.push_back(pins);
            void'(hist.pop_front());
            nl = mlevel;
            for (int b = 0; b <= NI; b++) begin
                diff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (hist[hist.size() - 1 - SYNC - j][b] == mlevel[b]) diff = 1'b0;
                if (diff) nl[b] = ~mlevel[b];
            end
            exp_rise = nl[NI-1:0] & ~mlevel[NI-1:0];
            exp_fall = ~nl[NI-1:0] & mlevel[NI-1:0];
            exp_soc  = (btn_run >= HOLD + 1);
            btn_run  = nl[NI] ? btn_run + 1 : 0;
            mlevel   = nl;
        end
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, fall_at, rise_at, nr, pulses, btn_left;
        int pat[10];
        logic [NI-1:0] lv_snap;
        logic seen_soc;
        pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

        // Power-on
        rst_ni     = 1'b0;
        rst_btn_ni = 1'b1;
        raw_i      = '0;
        model_reset();
        #2;
        check_outputs();
        repeat (3) tick();
        rst_ni = 1'b1;
        n = 0;
        while (soc_rst_no !== 1'b1 && n < 40) begin tick(); n++; end
        chk("poweron_release_edges", 32'(n), 32'd15);

        // Clean press on bit 2
        raw_i[2] = 1'b1;
        n = 0;
        while (rise_o[2] !== 1'b1 && n < 20) begin tick(); n++; end
        chk("press_edges", 32'(n), 32'd6);
        chk("press_level", 32'(level_o[2]), 32'd1);
        tick();
        chk("press_rise_width", 32'(rise_o[2]), 32'd0);
        chk("press_other_bits", 32'(level_o & 7'b1111011), 32'd0);

        // Glitch rejection: 3 cycles then 4 cycles on bit 0
        raw_i[0] = 1'b1;
        repeat (3) tick();
        raw_i[0] = 1'b0;
        pulses = 0;
        repeat (8) begin
            tick();
            if (rise_o[0] === 1'b1 || fall_o[0] === 1'b1) pulses++;
        end
        chk("glitch3_level", 32'(level_o[0]), 32'd0);
        chk("glitch3_pulses", 32'(pulses), 32'd0);
        raw_i[0] = 1'b1;
        rise_at  = 0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 5) raw_i[0] = 1'b0;
            tick();
            if (rise_o[0] === 1'b1) rise_at = i;
        end
        chk("pulse4_rise_edge", 32'(rise_at), 32'd6);

        // Bounce on bit 4
        nr = 0;
        rise_at = -100;
        for (int i = 0; i < 20; i++) begin
            raw_i[4] = (i < 10) ? pat[i][0] : 1'b1;
            tick();
            if (rise_o[4] === 1'b1) begin nr++; rise_at = i; end
        end
        chk("bounce_rise_count", 32'(nr), 32'd1);
        chk("bounce_rise_edge", 32'(rise_at - 4), 32'd6);

        // Toggling every cycle changes nothing
        lv_snap = level_o;
        pulses  = 0;
        repeat (16) begin
            raw_i = ~raw_i;
            tick();
            if ((rise_o | fall_o) !== '0) pulses++;
        end
        chk("toggle_level", 32'(level_o), 32'(lv_snap));
        chk("toggle_pulses", 32'(pulses), 32'd0);
        raw_i = lv_snap;
        repeat (8) tick();

        // Button reset while running
        chk("run_before_press", 32'(soc_rst_no), 32'd1);
        rst_btn_ni = 1'b0;
        fall_at    = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (soc_rst_no !== 1'b1 && fall_at == 0) fall_at = i;
        end
        chk("btn_fall_edge", 32'(fall_at), 32'd7);
        rst_btn_ni = 1'b1;
        n = 0;
        while (soc_rst_no !== 1'b1 && n < 40) begin tick(); n++; end
        chk("btn_release_edges", 32'(n), 32'd15);

        // Press debounces exactly when the hold count expires: press wins
        rst_btn_ni = 1'b0;
        repeat (8) tick();
        rst_btn_ni = 1'b1;
        repeat (8) tick();
        rst_btn_ni = 1'b0;
        seen_soc   = 1'b0;
        repeat (20) begin
            tick();
            if (soc_rst_no === 1'b1) seen_soc = 1'b1;
        end
        chk("collision_no_run", 32'(seen_soc), 32'd0);

        // Async reset mid-hold (hold count 5)
        rst_btn_ni = 1'b1;
        repeat (12) tick();
        chk("midhold_soc", 32'(soc_rst_no), 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("async_soc", 32'(soc_rst_no), 32'd0);
        chk("async_level", 32'(level_o), 32'd0);
        repeat (2) tick();
        rst_ni = 1'b1;
        n = 0;
        while (soc_rst_no !== 1'b1 && n < 40) begin tick(); n++; end
        chk("async_release_edges", 32'(n), 32'd15);

        // Randomized pins and button presses
        btn_left = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) raw_i = NI'($urandom);
            if (btn_left > 0) begin
                rst_btn_ni = 1'b0;
                btn_left--;
            end else begin
                rst_btn_ni = 1'b1;
                if ($urandom_range(0, 119) == 0) btn_left = $urandom_range(2, 10);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
